// File: rtl/usr_shift_sequencer.sv
// Command sequencer for a 4-bit universal shift register: runs one TX or RX
// command per valid/ready handshake, captures the USR word and pulses done.
module usr_shift_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             abort,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_p_data,
    output logic             usr_s_in,
    output logic             tx_active,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] rx_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE
    } state_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       op_q, op_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            op_q      <= '0;
            fill_q    <= 1'b0;
            data_q    <= '0;
            rx_q      <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            op_q      <= op_d;
            fill_q    <= fill_d;
            data_q    <= data_d;
            rx_q      <= rx_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        op_d       = op_q;
        fill_d     = fill_q;
        data_d     = data_q;
        rx_d       = rx_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        usr_select = SEL_HOLD;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    len_d  = cmd_len;
                    fill_d = cmd_fill;
                    data_d = tx_data;
                    cnt_d  = '0;
                    if (!cmd_op[1])          state_d = S_LOAD;
                    else if (cmd_len == '0)  state_d = S_CAPTURE;
                    else                     state_d = S_SHIFT;
                end
            end
            S_LOAD: begin
                usr_select = SEL_LOAD;
                cnt_d      = '0;
                state_d    = (len_q == '0) ? S_CAPTURE : S_SHIFT;
            end
            S_SHIFT: begin
                usr_select = op_q[0] ? SEL_LEFT : SEL_RIGHT;
                cnt_d      = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rx_d    = usr_q;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every non-idle transition, including CAPTURE completion.
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            usr_select = SEL_HOLD;
            rx_d       = rx_q;
            done_d     = 1'b0;
            aborted_d  = 1'b1;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = ~cmd_ready;
    assign tx_active  = (state_q == S_SHIFT) && !op_q[1];
    assign usr_p_data = data_q;
    assign usr_s_in   = (state_q == S_IDLE) ? 1'b0 : (op_q[1] ? ser_in : fill_q);
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign rx_data    = rx_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer with a behavioural USR attached;
// expected selects and captured words flow through scoreboard queues.
module tb_usr_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_len;
    logic       cmd_fill;
    logic [3:0] tx_data;
    logic       abort;
    logic       ser_in;
    logic [3:0] usr_q;
    logic [1:0] usr_select;
    logic [3:0] usr_p_data;
    logic       usr_s_in;
    logic       tx_active;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] rx_data;
    logic       usr_s_out;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_sel[$];
    logic [3:0] exp_rx[$];
    logic       sout_log[0:15];

    always #5 clk = ~clk;

    usr_shift_sequencer #(.WIDTH(4), .LEN_W(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_fill(cmd_fill), .tx_data(tx_data),
        .abort(abort), .ser_in(ser_in), .usr_q(usr_q), .usr_select(usr_select),
        .usr_p_data(usr_p_data), .usr_s_in(usr_s_in), .tx_active(tx_active),
        .busy(busy), .done(done), .aborted(aborted), .rx_data(rx_data)
    );

    // Behavioural 4-bit USR with registered serial output.
    always_ff @(posedge clk) begin
        if (rst) begin
            usr_q     <= '0;
            usr_s_out <= 1'b0;
        end else begin
            case (usr_select)
                2'b01: begin usr_q <= {usr_s_in, usr_q[3:1]}; usr_s_out <= usr_q[0]; end
                2'b10: begin usr_q <= {usr_q[2:0], usr_s_in}; usr_s_out <= usr_q[3]; end
                2'b11: usr_q <= usr_p_data;
                default: ;
            endcase
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] len, input logic fill,
                           input logic [3:0] data, input logic [7:0] ser,
                           input logic [3:0] rx_exp, input string name);
        int lat, first, idx;
        logic [1:0] es;
        logic [3:0] er;
        logic s_exp, ta_exp;
        lat   = op[1] ? int'(len) + 2 : int'(len) + 3;
        first = op[1] ? 1 : 2;
        if (!op[1]) exp_sel.push_back(2'b11);
        for (int i = 0; i < int'(len); i++) exp_sel.push_back(op[0] ? 2'b10 : 2'b01);
        exp_sel.push_back(2'b00);
        exp_rx.push_back(rx_exp);

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_fill = fill; tx_data = data;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_c0 got=%b exp=1", name, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_len = ~len; cmd_fill = ~fill; tx_data = ~data;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            idx = cyc - first;
            ser_in = (idx >= 0 && idx < int'(len)) ? ser[idx] : 1'b0;
            @(negedge clk);
            sout_log[cyc] = usr_s_out;
            if (cyc < lat) begin
                es     = exp_sel.pop_front();
                s_exp  = op[1] ? ser_in : fill;
                ta_exp = !op[1] && idx >= 0 && idx < int'(len);
                total++;
                if (usr_select !== es) begin
                    bad++; $display("FAIL %s sel c%0d got=%b exp=%b", name, cyc, usr_select, es);
                end
                total++;
                if (usr_s_in !== s_exp) begin
                    bad++; $display("FAIL %s s_in c%0d got=%b exp=%b", name, cyc, usr_s_in, s_exp);
                end
                total++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    bad++; $display("FAIL %s busy c%0d done=%b busy=%b exp done=0 busy=1", name, cyc, done, busy);
                end
                total++;
                if (tx_active !== ta_exp) begin
                    bad++; $display("FAIL %s tx_active c%0d got=%b exp=%b", name, cyc, tx_active, ta_exp);
                end
            end else begin
                er = exp_rx.pop_front();
                total++;
                if (done !== 1'b1 || cmd_ready !== 1'b1 || aborted !== 1'b0) begin
                    bad++; $display("FAIL %s done c%0d done=%b ready=%b aborted=%b exp 1,1,0", name, cyc, done, cmd_ready, aborted);
                end
                total++;
                if (rx_data !== er) begin
                    bad++; $display("FAIL %s rx_data got=%b exp=%b", name, rx_data, er);
                end
                total++;
                if (usr_select !== 2'b00 || usr_s_in !== 1'b0) begin
                    bad++; $display("FAIL %s idle_out sel=%b s_in=%b exp 00,0", name, usr_select, usr_s_in);
                end
            end
            @(posedge clk); #1;
        end
        ser_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (usr_select !== 2'b00 || cmd_ready !== 1'b1 || done !== 1'b0 || aborted !== 1'b0 || rx_data !== 4'b0000) begin
            bad++;
            $display("FAIL reset sel=%b ready=%b done=%b aborted=%b rx=%b exp 00,1,0,0,0000",
                     usr_select, cmd_ready, done, aborted, rx_data);
        end
    endtask

    task automatic test_rx_msb();
        run_cmd(2'b11, 3'd4, 1'b0, 4'b0000, 8'b0000_1001, 4'b1001, "rx_msb");
    endtask

    task automatic test_rx_len0();
        run_cmd(2'b10, 3'd0, 1'b0, 4'b0000, 8'b0000_0000, 4'b1001, "rx_len0");
    endtask

    task automatic test_tx_lsb();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        run_cmd(2'b00, 3'd4, 1'b0, 4'b1011, 8'b0, 4'b0000, "tx_lsb");
        for (int k = 0; k < 4; k++) begin
            total++;
            if (sout_log[3 + k] !== exp_bits[k]) begin
                bad++; $display("FAIL tx_lsb s_out bit%0d got=%b exp=%b", k, sout_log[3 + k], exp_bits[k]);
            end
        end
    endtask

    task automatic test_tx_long();
        run_cmd(2'b00, 3'd6, 1'b1, 4'b1011, 8'b0, 4'b1111, "tx_long");
    endtask

    task automatic test_back_to_back();
        logic [3:0] er;
        exp_rx.push_back(4'b1011);
        exp_rx.push_back(4'b0010);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 3'd2; cmd_fill = 1'b0; tx_data = 4'b0000;
        ser_in = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 5) cmd_valid = 1'b0;
            ser_in = (cyc == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (cyc == 4 || cyc == 8) begin
                er = exp_rx.pop_front();
                total++;
                if (done !== 1'b1 || cmd_ready !== 1'b1 || rx_data !== er) begin
                    bad++; $display("FAIL b2b done c%0d done=%b ready=%b rx=%b exp 1,1,%b", cyc, done, cmd_ready, rx_data, er);
                end
            end else begin
                total++;
                if (cmd_ready !== 1'b0 || done !== 1'b0) begin
                    bad++; $display("FAIL b2b busy c%0d ready=%b done=%b exp 0,0", cyc, cmd_ready, done);
                end
                total++;
                if (usr_select !== ((cyc == 3 || cyc == 7) ? 2'b00 : 2'b01)) begin
                    bad++; $display("FAIL b2b sel c%0d got=%b", cyc, usr_select);
                end
            end
        end
        ser_in = 1'b0;
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 3'd4; cmd_fill = 1'b0; tx_data = 4'b0110;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (usr_select !== 2'b11) begin bad++; $display("FAIL abort load_sel got=%b exp=11", usr_select); end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (usr_select !== 2'b10) begin bad++; $display("FAIL abort shift_sel got=%b exp=10", usr_select); end
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        total++;
        if (usr_select !== 2'b00 || done !== 1'b0 || aborted !== 1'b0) begin
            bad++; $display("FAIL abort cycle sel=%b done=%b aborted=%b exp 00,0,0", usr_select, done, aborted);
        end
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || aborted !== 1'b1 || done !== 1'b0 || rx_data !== 4'b0010) begin
            bad++; $display("FAIL abort after ready=%b aborted=%b done=%b rx=%b exp 1,1,0,0010", cmd_ready, aborted, done, rx_data);
        end
        // abort in IDLE alongside a new command: command wins
        @(posedge clk); #1;
        abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 3'd0;
        @(negedge clk);
        total++;
        if (aborted !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort pulse_width aborted=%b done=%b exp 0,0", aborted, done);
        end
        @(posedge clk); #1 abort = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || aborted !== 1'b0) begin
            bad++; $display("FAIL abort idle_accept busy=%b aborted=%b exp 1,0", busy, aborted);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || aborted !== 1'b0 || rx_data !== 4'b1100) begin
            bad++; $display("FAIL abort idle_done done=%b aborted=%b rx=%b exp 1,0,1100", done, aborted, rx_data);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 3'd4; ser_in = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (usr_select !== 2'b10) begin bad++; $display("FAIL rst_mid pre sel=%b exp=10", usr_select); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (usr_select !== 2'b00 || cmd_ready !== 1'b1 || done !== 1'b0 || aborted !== 1'b0 || rx_data !== 4'b0000) begin
            bad++; $display("FAIL rst_mid sel=%b ready=%b done=%b aborted=%b rx=%b exp 00,1,0,0,0000",
                            usr_select, cmd_ready, done, aborted, rx_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || aborted !== 1'b0) begin
            bad++; $display("FAIL rst_mid later done=%b aborted=%b exp 0,0", done, aborted);
        end
        ser_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_fill = 1'b0;
        tx_data = '0; abort = 1'b0; ser_in = 1'b0;
        test_reset();
        test_rx_msb();
        test_rx_len0();
        test_tx_lsb();
        test_tx_long();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
